// File: rtl/frc_timer.sv
// frc_timer: 64-bit free-running machine timer with prescaler, atomic compare/read, and level interrupt.
//   clk, rst_n            clock; asynchronous active-low reset
//   io_we, io_re          single-cycle register write / read strobes
//   io_adr, io_wdata      word index (0 MTIME_LO, 1 MTIME_HI, 2 CMP_LO, 3 CMP_HI, 4 CTRL, 5 STATUS) and write data
//   io_rdata, io_rvalid   registered read data, valid one cycle after io_re
//   csr_mtie              machine timer interrupt enable
//   frc_cntr_val_leq      registered timer interrupt request (EN & csr_mtie & mtime >= cmp)
module frc_timer #(
   parameter logic [7:0]  DIV_RST = 8'd0,
   parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        io_we,
   input  logic        io_re,
   input  logic [2:0]  io_adr,
   input  logic [31:0] io_wdata,
   output logic [31:0] io_rdata,
   output logic        io_rvalid,
   input  logic        csr_mtie,
   output logic        frc_cntr_val_leq
);
   logic [63:0] mtime, cmp;
   logic [31:0] stage, shadow, rd_mux;
   logic [7:0]  pre, div;
   logic        en, wr_ctrl, clr, tick, ge;
   always_comb begin
      wr_ctrl = io_we && io_adr == 3'd4;
      clr     = wr_ctrl && io_wdata[1];
      tick    = en && pre == div;
      ge      = mtime >= cmp;
      case (io_adr)
         3'd0:    rd_mux = mtime[31:0];
         3'd1:    rd_mux = shadow;
         3'd2:    rd_mux = cmp[31:0];
         3'd3:    rd_mux = stage;
         3'd4:    rd_mux = {16'd0, div, 7'd0, en};
         3'd5:    rd_mux = {31'd0, ge};
         default: rd_mux = 32'd0;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime            <= 64'd0;
         pre              <= 8'd0;
         cmp              <= CMP_RST;
         stage            <= CMP_RST[63:32];
         shadow           <= 32'd0;
         en               <= 1'b0;
         div              <= DIV_RST;
         io_rdata         <= 32'd0;
         io_rvalid        <= 1'b0;
         frc_cntr_val_leq <= 1'b0;
      end else begin
         // any CTRL write restarts the prescaler phase
         if (wr_ctrl) begin
            en  <= io_wdata[0];
            div <= io_wdata[15:8];
            pre <= 8'd0;
         end else if (en)
            pre <= tick ? 8'd0 : pre + 8'd1;
         // software writes win over a coincident tick, without carry into the other half
         if (clr)
            mtime <= 64'd0;
         else if (io_we && io_adr == 3'd0)
            mtime[31:0] <= io_wdata;
         else if (io_we && io_adr == 3'd1)
            mtime[63:32] <= io_wdata;
         else if (tick)
            mtime <= mtime + 64'd1;
         // compare is only updated as a whole on the low-half write
         if (io_we && io_adr == 3'd3)
            stage <= io_wdata;
         if (io_we && io_adr == 3'd2)
            cmp <= {stage, io_wdata};
         io_rvalid <= io_re;
         if (io_re)
            io_rdata <= rd_mux;
         if (io_re && io_adr == 3'd0)
            shadow <= mtime[63:32];
         frc_cntr_val_leq <= en & csr_mtie & ge;
      end
   end
endmodule

// File: tb/tb_frc_timer.sv
// tb_frc_timer: directed self-checking bench for frc_timer.
module tb_frc_timer;
   logic        clk, rst_n, io_we, io_re, csr_mtie;
   logic [2:0]  io_adr;
   logic [31:0] io_wdata, io_rdata, d, d2;
   logic        io_rvalid, frc_cntr_val_leq;
   int          total, bad;

   frc_timer dut (
      .clk(clk), .rst_n(rst_n), .io_we(io_we), .io_re(io_re), .io_adr(io_adr),
      .io_wdata(io_wdata), .io_rdata(io_rdata), .io_rvalid(io_rvalid),
      .csr_mtie(csr_mtie), .frc_cntr_val_leq(frc_cntr_val_leq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // bus tasks are entered at a negedge; the access lands on the following posedge
   task automatic wr(input logic [2:0] a, input logic [31:0] v);
      io_we = 1'b1; io_re = 1'b0; io_adr = a; io_wdata = v;
      @(negedge clk);
      io_we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] v);
      io_re = 1'b1; io_we = 1'b0; io_adr = a;
      @(negedge clk);
      io_re = 1'b0;
      v = io_rdata;
   endtask

   task automatic test_reset;
      logic [31:0] exp [8];
      exp = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
      total++; if (io_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", io_rvalid); end
      total++; if (io_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", io_rdata); end
      total++; if (frc_cntr_val_leq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", frc_cntr_val_leq); end
      for (int i = 0; i < 8; i++) begin
         rd(3'(i), d);
         total++; if (d !== exp[i]) begin bad++; $display("FAIL rst_reg%0d got=%h exp=%h", i, d, exp[i]); end
         total++; if (io_rvalid !== 1'b1) begin bad++; $display("FAIL rst_rvalid%0d got=%b exp=1", i, io_rvalid); end
      end
   endtask

   task automatic test_count;
      csr_mtie = 1'b1;
      wr(3'd3, 32'd0);
      wr(3'd2, 32'd10);
      wr(3'd4, 32'h1);
      repeat (10) @(negedge clk);
      total++; if (frc_cntr_val_leq !== 1'b0) begin bad++; $display("FAIL cnt_irq_early got=%b exp=0", frc_cntr_val_leq); end
      @(negedge clk);
      total++; if (frc_cntr_val_leq !== 1'b1) begin bad++; $display("FAIL cnt_irq_on got=%b exp=1", frc_cntr_val_leq); end
      repeat (3) @(negedge clk);
      total++; if (frc_cntr_val_leq !== 1'b1) begin bad++; $display("FAIL cnt_irq_hold got=%b exp=1", frc_cntr_val_leq); end
      wr(3'd4, 32'h0);
      total++; if (frc_cntr_val_leq !== 1'b1) begin bad++; $display("FAIL cnt_irq_lag got=%b exp=1", frc_cntr_val_leq); end
      @(negedge clk);
      total++; if (frc_cntr_val_leq !== 1'b0) begin bad++; $display("FAIL cnt_irq_en_off got=%b exp=0", frc_cntr_val_leq); end
      rd(3'd0, d);
      total++; if (d !== 32'd15) begin bad++; $display("FAIL cnt_mtime got=%0d exp=15", d); end
   endtask

   task automatic test_prescale;
      wr(3'd4, 32'h0302);
      wr(3'd4, 32'h0301);
      repeat (6) @(negedge clk);
      wr(3'd4, 32'h0300);
      rd(3'd0, d);
      total++; if (d !== 32'd1) begin bad++; $display("FAIL pre_count got=%0d exp=1", d); end
      repeat (5) @(negedge clk);
      rd(3'd0, d);
      total++; if (d !== 32'd1) begin bad++; $display("FAIL pre_frozen got=%0d exp=1", d); end
      wr(3'd4, 32'h0301);
      repeat (3) @(negedge clk);
      rd(3'd0, d);
      total++; if (d !== 32'd1) begin bad++; $display("FAIL pre_before_tick got=%0d exp=1", d); end
      rd(3'd0, d);
      total++; if (d !== 32'd2) begin bad++; $display("FAIL pre_after_tick got=%0d exp=2", d); end
      wr(3'd4, 32'h0300);
      rd(3'd4, d);
      total++; if (d !== 32'h0300) begin bad++; $display("FAIL pre_ctrl got=%h exp=00000300", d); end
   endtask

   task automatic test_carry;
      wr(3'd4, 32'h2);
      wr(3'd0, 32'hFFFF_FFFF);
      wr(3'd4, 32'h1);
      wr(3'd4, 32'h0);
      rd(3'd0, d); rd(3'd1, d2);
      total++; if ({d2, d} !== 64'h1_0000_0000) begin bad++; $display("FAIL carry got=%h exp=0000000100000000", {d2, d}); end
      wr(3'd4, 32'h2);
      wr(3'd0, 32'hFFFF_FFFE);
      wr(3'd4, 32'h1);
      @(negedge clk);
      rd(3'd0, d); rd(3'd1, d2);
      total++; if ({d2, d} !== 64'h0_FFFF_FFFF) begin bad++; $display("FAIL snap_straddle got=%h exp=00000000ffffffff", {d2, d}); end
      rd(3'd0, d); rd(3'd1, d2);
      total++; if ({d2, d} !== 64'h1_0000_0001) begin bad++; $display("FAIL snap_after got=%h exp=0000000100000001", {d2, d}); end
      wr(3'd4, 32'h0);
   endtask

   task automatic test_write_tick;
      wr(3'd4, 32'h2);
      wr(3'd4, 32'h1);
      wr(3'd0, 32'd100);
      rd(3'd0, d);
      total++; if (d !== 32'd100) begin bad++; $display("FAIL wtick_lo got=%0d exp=100", d); end
      wr(3'd4, 32'h3);
      rd(3'd0, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL clr_tick got=%0d exp=0", d); end
      wr(3'd4, 32'h0);
   endtask

   task automatic test_cmp;
      csr_mtie = 1'b1;
      wr(3'd4, 32'h2);
      wr(3'd0, 32'd7);
      wr(3'd3, 32'd0);
      wr(3'd2, 32'd5);
      wr(3'd4, 32'hFF01);
      total++; if (frc_cntr_val_leq !== 1'b0) begin bad++; $display("FAIL cmp_irq_pre got=%b exp=0", frc_cntr_val_leq); end
      @(negedge clk);
      total++; if (frc_cntr_val_leq !== 1'b1) begin bad++; $display("FAIL cmp_irq_on got=%b exp=1", frc_cntr_val_leq); end
      wr(3'd3, 32'd1);
      @(negedge clk);
      total++; if (frc_cntr_val_leq !== 1'b1) begin bad++; $display("FAIL cmp_staged got=%b exp=1", frc_cntr_val_leq); end
      rd(3'd5, d);
      total++; if (d !== 32'd1) begin bad++; $display("FAIL cmp_status1 got=%h exp=1", d); end
      wr(3'd2, 32'd0);
      total++; if (frc_cntr_val_leq !== 1'b1) begin bad++; $display("FAIL cmp_commit_lag got=%b exp=1", frc_cntr_val_leq); end
      @(negedge clk);
      total++; if (frc_cntr_val_leq !== 1'b0) begin bad++; $display("FAIL cmp_commit_off got=%b exp=0", frc_cntr_val_leq); end
      rd(3'd3, d); rd(3'd2, d2);
      total++; if ({d, d2} !== 64'h1_0000_0000) begin bad++; $display("FAIL cmp_readback got=%h exp=0000000100000000", {d, d2}); end
      rd(3'd5, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL cmp_status0 got=%h exp=0", d); end
      wr(3'd3, 32'd0);
      wr(3'd2, 32'd5);
      wr(3'd0, 32'd3);
      @(negedge clk);
      total++; if (frc_cntr_val_leq !== 1'b0) begin bad++; $display("FAIL mtime_below got=%b exp=0", frc_cntr_val_leq); end
      wr(3'd0, 32'd9);
      @(negedge clk);
      total++; if (frc_cntr_val_leq !== 1'b1) begin bad++; $display("FAIL mtime_above got=%b exp=1", frc_cntr_val_leq); end
      csr_mtie = 1'b0;
      @(negedge clk);
      total++; if (frc_cntr_val_leq !== 1'b0) begin bad++; $display("FAIL mtie_off got=%b exp=0", frc_cntr_val_leq); end
      rd(3'd5, d);
      total++; if (d !== 32'd1) begin bad++; $display("FAIL mtie_status got=%h exp=1", d); end
      csr_mtie = 1'b1;
      @(negedge clk);
      total++; if (frc_cntr_val_leq !== 1'b1) begin bad++; $display("FAIL mtie_on got=%b exp=1", frc_cntr_val_leq); end
   endtask

   task automatic test_rw;
      wr(3'd3, 32'h1234);
      io_we = 1'b1; io_re = 1'b1; io_adr = 3'd3; io_wdata = 32'hABCD;
      @(negedge clk);
      io_we = 1'b0; io_re = 1'b0;
      total++; if (io_rdata !== 32'h1234) begin bad++; $display("FAIL rw_old got=%h exp=00001234", io_rdata); end
      @(negedge clk);
      total++; if (io_rvalid !== 1'b0) begin bad++; $display("FAIL rvalid_idle got=%b exp=0", io_rvalid); end
      total++; if (io_rdata !== 32'h1234) begin bad++; $display("FAIL rdata_hold got=%h exp=00001234", io_rdata); end
      rd(3'd3, d);
      total++; if (d !== 32'hABCD) begin bad++; $display("FAIL rw_new got=%h exp=0000abcd", d); end
      wr(3'd6, 32'hFFFF_FFFF);
      rd(3'd6, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL unmapped6 got=%h exp=0", d); end
      rd(3'd7, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL unmapped7 got=%h exp=0", d); end
      rd(3'd4, d);
      total++; if (d !== 32'h0000_FF01) begin bad++; $display("FAIL ctrl_read got=%h exp=0000ff01", d); end
   endtask

   task automatic test_reset_mid;
      io_re = 1'b1; io_adr = 3'd2;
      #2 rst_n = 1'b0;
      #1;
      total++; if ({frc_cntr_val_leq, io_rvalid} !== 2'b00) begin bad++; $display("FAIL async_rst got=%b exp=00", {frc_cntr_val_leq, io_rvalid}); end
      total++; if (io_rdata !== 32'd0) begin bad++; $display("FAIL async_rdata got=%h exp=0", io_rdata); end
      io_re = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      total++; if (io_rvalid !== 1'b0) begin bad++; $display("FAIL rst_no_pending got=%b exp=0", io_rvalid); end
      rd(3'd2, d); rd(3'd3, d2);
      total++; if ({d2, d} !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL rst_cmp got=%h exp=ffffffffffffffff", {d2, d}); end
      rd(3'd4, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_ctrl got=%h exp=0", d); end
      rd(3'd0, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_mtime got=%h exp=0", d); end
      total++; if (frc_cntr_val_leq !== 1'b0) begin bad++; $display("FAIL rst_irq_after got=%b exp=0", frc_cntr_val_leq); end
   endtask

   initial begin
      total = 0; bad = 0;
      rst_n = 1'b0; io_we = 1'b0; io_re = 1'b0; io_adr = 3'd0; io_wdata = 32'd0; csr_mtie = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      test_reset;
      test_count;
      test_prescale;
      test_carry;
      test_write_tick;
      test_cmp;
      test_rw;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
